// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg
// Shared definitions for the control pipeline. It holds the RV32I major-opcode
// constants (instr[6:2]), the per-stage action encoding, and the writes_rd()
// decode used to build the rd-write flags for hazard and forwarding logic.
package ctrl_pipe_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_LUI    = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_JAL    = 5'b11011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_OP     = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_STORE  = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b11000;

    // What a stage register does on the coming edge, in priority order.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } stage_act_e;

    // True for the opcode classes that produce a register result.
    function automatic logic writes_rd(input logic [OPC_W-1:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OPIMM, OPC_OP:  writes_rd = 1'b1;
            OPC_STORE, OPC_BRANCH:        writes_rd = 1'b0;
            default:                      writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_stage.sv
// control_stage
// One stage register of the control pipeline. Each clock it either clears
// (flush), keeps its contents (hold), inserts a bubble because the stage
// upstream is frozen, or loads the word offered by the upstream source.
// Ports:
//   clk, rst                       clock and async active-high reset
//   flush, hold, up_hold           kill / freeze this stage / upstream frozen
//   src_valid/src_op/src_f3/src_rd word offered by the upstream source
//   valid/op/f3/rd                 registered stage contents
//   bubble                         this stage takes a bubble on the coming edge
module control_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int OP_W = 5,
    parameter int F3_W = 3,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            hold,
    input  logic            up_hold,
    input  logic            src_valid,
    input  logic [OP_W-1:0] src_op,
    input  logic [F3_W-1:0] src_f3,
    input  logic [RD_W-1:0] src_rd,
    output logic            valid,
    output logic [OP_W-1:0] op,
    output logic [F3_W-1:0] f3,
    output logic [RD_W-1:0] rd,
    output logic            bubble
);

    stage_act_e act;

    // Flush beats hold, hold beats bubble, and a bubble is only needed when
    // this stage is free to move but its upstream neighbour is frozen.
    always_comb begin
        if (flush) begin
            act = ACT_FLUSH;
        end else if (hold) begin
            act = ACT_HOLD;
        end else if (up_hold) begin
            act = ACT_BUBBLE;
        end else begin
            act = ACT_LOAD;
        end
    end

    assign bubble = (act == ACT_BUBBLE);

    // Invalid words always carry zeroed fields, so a load of an invalid source
    // also zeroes them; downstream stages can then copy blindly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            op    <= '0;
            f3    <= '0;
            rd    <= '0;
        end else begin
            case (act)
                ACT_LOAD: begin
                    valid <= src_valid;
                    op    <= src_valid ? src_op : '0;
                    f3    <= src_valid ? src_f3 : '0;
                    rd    <= src_valid ? src_rd : '0;
                end
                ACT_HOLD: begin
                end
                default: begin
                    valid <= 1'b0;
                    op    <= '0;
                    f3    <= '0;
                    rd    <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/control_pipe.sv
// control_pipe
// Multi-stage control pipeline carrying {valid, op, f3, rd} from decode to
// writeback. Builds the hold chain from the per-stage stalls, chains DEPTH
// control_stage registers, decodes per-stage rd-write flags and counts the
// bubbles inserted in a saturating counter.
// Ports:
//   clk, rst                           clock and async active-high reset
//   in_valid/in_op/in_f3/in_rd         control word from decode
//   in_ready                           stage 0 loads this cycle
//   stall, flush                       per-stage hold / kill requests
//   stg_valid/stg_op/stg_f3/stg_rd     per-stage contents, stage i at [i*W +: W]
//   stg_wr                             per-stage "writes a nonzero rd"
//   out_op/out_f3/out_rd/out_wr        writeback stage fields
//   bubble_cnt                         saturating bubble count
module control_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int OP_W  = 5,
    parameter int F3_W  = 3,
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [OP_W-1:0]        in_op,
    input  logic [F3_W-1:0]        in_f3,
    input  logic [RD_W-1:0]        in_rd,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       flush,
    output logic [DEPTH-1:0]       stg_valid,
    output logic [DEPTH*OP_W-1:0]  stg_op,
    output logic [DEPTH*F3_W-1:0]  stg_f3,
    output logic [DEPTH*RD_W-1:0]  stg_rd,
    output logic [DEPTH-1:0]       stg_wr,
    output logic [OP_W-1:0]        out_op,
    output logic [F3_W-1:0]        out_f3,
    output logic [RD_W-1:0]        out_rd,
    output logic                   out_wr,
    output logic [CNT_W-1:0]       bubble_cnt
);

    // Wide enough that adding up to DEPTH bubbles to a full counter cannot wrap.
    localparam int SUM_W = CNT_W + $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      hold;
    logic [DEPTH-1:0]      up_hold;
    logic [DEPTH-1:0]      bubble;
    logic [DEPTH-1:0]      src_valid;
    logic [DEPTH*OP_W-1:0] src_op;
    logic [DEPTH*F3_W-1:0] src_f3;
    logic [DEPTH*RD_W-1:0] src_rd;
    logic [SUM_W-1:0]      cnt_sum;

    assign in_ready = ~hold[0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // A stall anywhere downstream freezes this stage as well.
        assign hold[i] = |stall[DEPTH-1:i];

        if (i == 0) begin : g_first
            assign up_hold[i]               = 1'b0;
            assign src_valid[i]             = in_valid;
            assign src_op[i*OP_W +: OP_W]   = in_op;
            assign src_f3[i*F3_W +: F3_W]   = in_f3;
            assign src_rd[i*RD_W +: RD_W]   = in_rd;
        end else begin : g_rest
            assign up_hold[i]               = hold[i-1];
            assign src_valid[i]             = stg_valid[i-1];
            assign src_op[i*OP_W +: OP_W]   = stg_op[(i-1)*OP_W +: OP_W];
            assign src_f3[i*F3_W +: F3_W]   = stg_f3[(i-1)*F3_W +: F3_W];
            assign src_rd[i*RD_W +: RD_W]   = stg_rd[(i-1)*RD_W +: RD_W];
        end

        control_stage #(
            .OP_W (OP_W),
            .F3_W (F3_W),
            .RD_W (RD_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush[i]),
            .hold      (hold[i]),
            .up_hold   (up_hold[i]),
            .src_valid (src_valid[i]),
            .src_op    (src_op[i*OP_W +: OP_W]),
            .src_f3    (src_f3[i*F3_W +: F3_W]),
            .src_rd    (src_rd[i*RD_W +: RD_W]),
            .valid     (stg_valid[i]),
            .op        (stg_op[i*OP_W +: OP_W]),
            .f3        (stg_f3[i*F3_W +: F3_W]),
            .rd        (stg_rd[i*RD_W +: RD_W]),
            .bubble    (bubble[i])
        );

        // x0 is hardwired, so a write to it is never a hazard.
        assign stg_wr[i] = stg_valid[i]
                         && writes_rd(OPC_W'(stg_op[i*OP_W +: OP_W]))
                         && (stg_rd[i*RD_W +: RD_W] != '0);
    end

    assign out_op = stg_op[(DEPTH-1)*OP_W +: OP_W];
    assign out_f3 = stg_f3[(DEPTH-1)*F3_W +: F3_W];
    assign out_rd = stg_rd[(DEPTH-1)*RD_W +: RD_W];
    assign out_wr = stg_wr[DEPTH-1];

    // Sum this cycle's bubbles onto the current count in a widened adder.
    always_comb begin
        cnt_sum = {{(SUM_W-CNT_W){1'b0}}, bubble_cnt};
        for (int i = 0; i < DEPTH; i++) begin
            cnt_sum = cnt_sum + SUM_W'(bubble[i]);
        end
    end

    // Clamp at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (cnt_sum > {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}}) begin
            bubble_cnt <= '1;
        end else begin
            bubble_cnt <= cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe
// Directed bench for control_pipe (DEPTH=3). A scoreboard queue holds the words
// expected at the writeback stage; a monitor pops and compares whenever a new
// valid word arrives there. A second instance with a 2-bit counter shares the
// inputs to exercise bubble-counter saturation.
module tb_control_pipe;

    localparam int DEPTH = 3;
    localparam int OP_W  = 5;
    localparam int F3_W  = 3;
    localparam int RD_W  = 5;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [F3_W-1:0] f3;
        logic [RD_W-1:0] rd;
        logic            wr;
    } word_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic [OP_W-1:0]       in_op;
    logic [F3_W-1:0]       in_f3;
    logic [RD_W-1:0]       in_rd;
    logic [DEPTH-1:0]      stall;
    logic [DEPTH-1:0]      flush;

    logic                  in_ready;
    logic [DEPTH-1:0]      stg_valid;
    logic [DEPTH*OP_W-1:0] stg_op;
    logic [DEPTH*F3_W-1:0] stg_f3;
    logic [DEPTH*RD_W-1:0] stg_rd;
    logic [DEPTH-1:0]      stg_wr;
    logic [OP_W-1:0]       out_op;
    logic [F3_W-1:0]       out_f3;
    logic [RD_W-1:0]       out_rd;
    logic                  out_wr;
    logic [15:0]           bubble_cnt;

    logic                  sat_in_ready;
    logic [DEPTH-1:0]      sat_valid;
    logic [DEPTH*OP_W-1:0] sat_op;
    logic [DEPTH*F3_W-1:0] sat_f3;
    logic [DEPTH*RD_W-1:0] sat_rd;
    logic [DEPTH-1:0]      sat_wr;
    logic [OP_W-1:0]       sat_out_op;
    logic [F3_W-1:0]       sat_out_f3;
    logic [RD_W-1:0]       sat_out_rd;
    logic                  sat_out_wr;
    logic [1:0]            sat_cnt;

    word_t sb[$];
    word_t exp_word;
    word_t act_word;
    bit    held_last = 1'b0;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    control_pipe #(
        .DEPTH(DEPTH), .OP_W(OP_W), .F3_W(F3_W), .RD_W(RD_W), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_op(in_op), .in_f3(in_f3), .in_rd(in_rd),
        .in_ready(in_ready), .stall(stall), .flush(flush),
        .stg_valid(stg_valid), .stg_op(stg_op), .stg_f3(stg_f3), .stg_rd(stg_rd),
        .stg_wr(stg_wr), .out_op(out_op), .out_f3(out_f3), .out_rd(out_rd),
        .out_wr(out_wr), .bubble_cnt(bubble_cnt)
    );

    control_pipe #(
        .DEPTH(DEPTH), .OP_W(OP_W), .F3_W(F3_W), .RD_W(RD_W), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_op(in_op), .in_f3(in_f3), .in_rd(in_rd),
        .in_ready(sat_in_ready), .stall(stall), .flush(flush),
        .stg_valid(sat_valid), .stg_op(sat_op), .stg_f3(sat_f3), .stg_rd(sat_rd),
        .stg_wr(sat_wr), .out_op(sat_out_op), .out_f3(sat_out_f3), .out_rd(sat_out_rd),
        .out_wr(sat_out_wr), .bubble_cnt(sat_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] op,
                                 input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [2:0] st, input logic [2:0] fl);
        in_valid = v;
        in_op    = op;
        in_f3    = f3;
        in_rd    = rd;
        stall    = st;
        flush    = fl;
        #1;
    endtask

    task automatic expectWord(input logic [4:0] op, input logic [2:0] f3,
                              input logic [4:0] rd, input logic wr);
        word_t w;
        w.op = op;
        w.f3 = f3;
        w.rd = rd;
        w.wr = wr;
        sb.push_back(w);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Remember whether stage DEPTH-1 was frozen at the last edge, so a held
    // word is not scored twice.
    initial begin
        forever begin
            @(posedge clk);
            held_last = stall[DEPTH-1];
        end
    end

    // Scoreboard monitor: each newly arrived valid writeback word is compared
    // against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && stg_valid[DEPTH-1] === 1'b1 && !held_last) begin
                act_word.op = out_op;
                act_word.f3 = out_f3;
                act_word.rd = out_rd;
                act_word.wr = out_wr;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_unexpected actual=%0h expected=none",
                             act_word);
                end else begin
                    exp_word = sb.pop_front();
                    if (act_word !== exp_word) begin
                        errors++;
                        $display("[TB] FAIL scoreboard_word actual=%0h expected=%0h",
                                 act_word, exp_word);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 5'd0, 3'd0, 5'd0, 3'b000, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", stg_valid, 3'b000);
        checkOutput("reset_bubble", bubble_cnt, 0);
        checkOutput("reset_ready", in_ready, 1);
        rst = 1'b0;

        // Single OP word flows through in three clocks.
        applyStimulus(1, 5'b01100, 3'd0, 5'd5, 3'b000, 3'b000);
        expectWord(5'b01100, 3'd0, 5'd5, 1'b1);
        checkOutput("flow_ready0", in_ready, 1);
        tick();
        applyStimulus(0, 5'd0, 3'd0, 5'd0, 3'b000, 3'b000);
        checkOutput("flow_ready1", in_ready, 1);
        tick();
        tick();
        checkOutput("flow_valid", stg_valid, 3'b100);
        checkOutput("flow_out_rd", out_rd, 5);
        checkOutput("flow_out_wr", out_wr, 1);
        tick();

        // Write decode: STORE, LOAD to x0, JAL, LUI, BRANCH back to back.
        applyStimulus(1, 5'b01000, 3'd2, 5'd3, 3'b000, 3'b000);
        expectWord(5'b01000, 3'd2, 5'd3, 1'b0);
        tick();
        applyStimulus(1, 5'b00000, 3'd2, 5'd0, 3'b000, 3'b000);
        expectWord(5'b00000, 3'd2, 5'd0, 1'b0);
        tick();
        applyStimulus(1, 5'b11011, 3'd0, 5'd1, 3'b000, 3'b000);
        expectWord(5'b11011, 3'd0, 5'd1, 1'b1);
        tick();
        checkOutput("wr_decode", stg_wr, 3'b001);
        applyStimulus(1, 5'b01101, 3'd0, 5'd31, 3'b000, 3'b000);
        expectWord(5'b01101, 3'd0, 5'd31, 1'b1);
        tick();
        applyStimulus(1, 5'b11000, 3'd1, 5'd4, 3'b000, 3'b000);
        expectWord(5'b11000, 3'd1, 5'd4, 1'b0);
        tick();
        applyStimulus(0, 5'd0, 3'd0, 5'd0, 3'b000, 3'b000);
        repeat (4) tick();

        // Stall stage 1 for two cycles with stages 0 and 1 occupied.
        applyStimulus(1, 5'b00100, 3'd1, 5'd10, 3'b000, 3'b000);
        expectWord(5'b00100, 3'd1, 5'd10, 1'b1);
        tick();
        applyStimulus(1, 5'b00101, 3'd0, 5'd11, 3'b000, 3'b000);
        expectWord(5'b00101, 3'd0, 5'd11, 1'b1);
        tick();
        applyStimulus(1, 5'b01100, 3'd7, 5'd12, 3'b010, 3'b000);
        expectWord(5'b01100, 3'd7, 5'd12, 1'b1);
        checkOutput("stall_ready", in_ready, 0);
        tick();
        tick();
        checkOutput("stall_valid", stg_valid, 3'b011);
        checkOutput("stall_rd", stg_rd, {5'd0, 5'd10, 5'd11});
        checkOutput("stall_bubbles", bubble_cnt, 2);
        applyStimulus(1, 5'b01100, 3'd7, 5'd12, 3'b000, 3'b000);
        checkOutput("stall_release_ready", in_ready, 1);
        tick();
        applyStimulus(0, 5'd0, 3'd0, 5'd0, 3'b000, 3'b000);
        checkOutput("stall_resume_rd", stg_rd, {5'd10, 5'd11, 5'd12});
        checkOutput("stall_resume_bubbles", bubble_cnt, 2);
        repeat (3) tick();

        // Flush stage 1 while stage 2 stalls: only stage 1 is cleared.
        applyStimulus(1, 5'b11001, 3'd3, 5'd20, 3'b000, 3'b000);
        expectWord(5'b11001, 3'd3, 5'd20, 1'b1);
        tick();
        applyStimulus(1, 5'b00000, 3'd4, 5'd21, 3'b000, 3'b000);
        tick();
        applyStimulus(1, 5'b00100, 3'd5, 5'd0, 3'b000, 3'b000);
        expectWord(5'b00100, 3'd5, 5'd0, 1'b0);
        tick();
        applyStimulus(0, 5'd0, 3'd0, 5'd0, 3'b100, 3'b010);
        checkOutput("flush_ready", in_ready, 0);
        tick();
        checkOutput("flush_valid", stg_valid, 3'b101);
        checkOutput("flush_f3", stg_f3, {3'd3, 3'd0, 3'd5});
        checkOutput("flush_rd", stg_rd, {5'd20, 5'd0, 5'd0});
        checkOutput("flush_bubbles", bubble_cnt, 2);
        applyStimulus(0, 5'd0, 3'd0, 5'd0, 3'b000, 3'b000);
        repeat (4) tick();

        // Saturation: stall stage 0 for five cycles, one bubble each.
        applyStimulus(0, 5'd0, 3'd0, 5'd0, 3'b001, 3'b000);
        tick();
        checkOutput("sat_first", sat_cnt, 3);
        checkOutput("sat_wide_first", bubble_cnt, 3);
        repeat (4) tick();
        checkOutput("sat_hold", sat_cnt, 3);
        checkOutput("sat_wide_total", bubble_cnt, 7);
        checkOutput("sat_ready", in_ready, 0);
        applyStimulus(0, 5'd0, 3'd0, 5'd0, 3'b000, 3'b000);
        tick();

        // Reset in the middle of a stall; these words must never emerge.
        applyStimulus(1, 5'b01100, 3'd0, 5'd8, 3'b000, 3'b000);
        tick();
        applyStimulus(1, 5'b00100, 3'd0, 5'd9, 3'b000, 3'b000);
        tick();
        applyStimulus(1, 5'b01100, 3'd1, 5'd13, 3'b010, 3'b000);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", stg_valid, 3'b000);
        checkOutput("midrst_op", stg_op, 0);
        checkOutput("midrst_rd", stg_rd, 0);
        checkOutput("midrst_bubbles", bubble_cnt, 0);
        checkOutput("midrst_sat", sat_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("postrst_ready", in_ready, 0);
        tick();
        checkOutput("postrst_valid", stg_valid, 3'b000);
        checkOutput("postrst_bubbles", bubble_cnt, 1);
        applyStimulus(0, 5'd0, 3'd0, 5'd0, 3'b000, 3'b000);
        repeat (5) tick();

        checkOutput("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
